// File: rtl/amp_cal_pkg.sv
// Shared types and helpers for the amplifier offset-calibration controller.
package amp_cal_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } cal_state_e;

    localparam int unsigned SETTLE_CYC_DEF = 8;
    localparam int unsigned CNT_W_DEF      = $clog2(SETTLE_CYC_DEF + 1);

    // Width of a counter that must reach settle_cyc.
    function automatic int unsigned cnt_width(input int unsigned settle_cyc);
        return $clog2(settle_cyc + 1);
    endfunction

    // Midscale trim code (MSB set, rest clear) in the low w bits.
    function automatic logic [31:0] midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Index of the lowest set bit of mask strictly above idx, or -1 if none.
    function automatic int lowest_set_above(input logic [31:0] mask, input int idx);
        int res;
        res = -1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (res < 0 && int'(i) > idx && mask[i]) res = int'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/amp_cal_sync.sv
// N-bit two-flop synchroniser for asynchronous comparator outputs.
module amp_cal_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; reset clears both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amp_offset_cal_ctrl.sv
// Sequential SAR offset calibration of a bank of trimmable amplifiers.
module amp_offset_cal_ctrl
    import amp_cal_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TRIM_W     = 6,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [N_CH-1:0]          cmp_out,
    output logic [N_CH-1:0]          cal_en,
    output logic [N_CH*TRIM_W-1:0]   trim,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          fail
);

    localparam int unsigned CNT_W = cnt_width(SETTLE_CYC);
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned KW    = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MID = TRIM_W'(midscale(TRIM_W));

    cal_state_e              state_q, state_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [KW-1:0]           k_q, k_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_CH*TRIM_W-1:0]  trim_q, trim_d;
    logic [N_CH-1:0]         cal_en_q, cal_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [N_CH-1:0]         fail_q, fail_d;
    logic [N_CH-1:0]         cmp_s;

    logic [TRIM_W-1:0]       cur, cur_n;
    int                      nxt, first;

    amp_cal_sync #(.W(N_CH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cmp_out),
        .q_o (cmp_s)
    );

    // State and datapath registers; reset puts every trim at midscale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            trim_q   <= {N_CH{MID}};
            cal_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            trim_q   <= trim_d;
            cal_en_q <= cal_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    // Next-state and SAR bit decisions; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        trim_d   = trim_q;
        cal_en_d = cal_en_q;
        done_d   = done_q;
        fail_d   = fail_q;
        cur      = trim_q[ch_q*TRIM_W +: TRIM_W];
        cur_n    = cur;
        nxt      = lowest_set_above(32'(mask_q), int'(ch_q));
        first    = lowest_set_above(32'(ch_mask), -1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mask_d = ch_mask;
                    done_d = 1'b0;
                    fail_d = fail_q & ~ch_mask;
                    if (ch_mask == '0) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = CH_W'(first);
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                trim_d[ch_q*TRIM_W +: TRIM_W] = MID;
                k_d          = KW'(TRIM_W - 1);
                cal_en_d     = '0;
                cal_en_d[ch_q] = 1'b1;
                cnt_d        = '0;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_DECIDE;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
            S_DECIDE: begin
                if (cmp_s[ch_q]) cur_n[k_q] = 1'b0;
                if (k_q != '0) begin
                    cur_n[k_q - 1'b1] = 1'b1;
                    k_d     = k_q - 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    fail_d[ch_q] = (cur_n == '0) || (cur_n == '1);
                    cal_en_d     = '0;
                    if (nxt < 0) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = CH_W'(nxt);
                        state_d = S_SETUP;
                    end
                end
                trim_d[ch_q*TRIM_W +: TRIM_W] = cur_n;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q == S_SETUP || state_q == S_SETTLE || state_q == S_DECIDE)) begin
            trim_d = trim_q;
            trim_d[ch_q*TRIM_W +: TRIM_W] = MID;
            fail_d   = fail_q;
            cal_en_d = '0;
            state_d  = S_IDLE;
        end

        busy_d = (state_d == S_SETUP) || (state_d == S_SETTLE) || (state_d == S_DECIDE);
    end

    assign cal_en = cal_en_q;
    assign trim   = trim_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign fail   = fail_q;

endmodule

// File: tb/tb_amp_offset_cal_ctrl.sv
// Self-checking bench for amp_offset_cal_ctrl with a behavioural SAR/comparator model.
module tb_amp_offset_cal_ctrl;

    localparam int N_CH       = 4;
    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 8;
    localparam int CH_LAT     = 1 + TRIM_W * (SETTLE_CYC + 1);
    localparam int MID        = 32;
    localparam int MAXC       = 63;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   abort;
    logic [N_CH-1:0]        ch_mask;
    logic [N_CH-1:0]        cmp_out;
    logic [N_CH-1:0]        cal_en;
    logic [N_CH*TRIM_W-1:0] trim;
    logic                   busy;
    logic                   done;
    logic [N_CH-1:0]        fail;

    int          checks = 0;
    int          errors = 0;
    int          tgt[N_CH];
    int          exp_trim[N_CH];
    logic [3:0]  exp_fail;

    amp_offset_cal_ctrl #(
        .N_CH       (N_CH),
        .TRIM_W     (TRIM_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .ch_mask (ch_mask),
        .cmp_out (cmp_out),
        .cal_en  (cal_en),
        .trim    (trim),
        .busy    (busy),
        .done    (done),
        .fail    (fail)
    );

    always #5 clk = ~clk;

    // Analog stand-in: each comparator is high when its code exceeds the channel's true offset.
    always_comb begin
        for (int i = 0; i < N_CH; i++)
            cmp_out[i] = (int'(trim[i*TRIM_W +: TRIM_W]) > tgt[i]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("%s trim[%0d]", tag, i), 32'(trim[i*TRIM_W +: TRIM_W]), exp_trim[i]);
        end
        chk({tag, " fail"}, 32'(fail), 32'(exp_fail));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_CH; i++) exp_trim[i] = MID;
        exp_fail = '0;
    endtask

    // Record the calibrated result of every masked channel in the model.
    task automatic model_update(input logic [3:0] m);
        for (int i = 0; i < N_CH; i++) begin
            if (m[i]) begin
                exp_trim[i] = tgt[i];
                exp_fail[i] = (tgt[i] == 0) || (tgt[i] == MAXC);
            end
        end
    endtask

    // One full run; optionally a second start pulse is offered at edge extra_e.
    task automatic run_cal(input logic [3:0] m, input int extra_e, input logic [3:0] m2, input string tag);
        int         n, lat;
        logic       overlap, early, busy_bad;
        logic [3:0] prev;
        logic [3:0] seq[$];
        logic [3:0] expseq[$];
        logic [3:0] obs;
        n = $countones(m);
        lat = n * CH_LAT + 1;
        overlap = 1'b0; early = 1'b0; busy_bad = 1'b0; prev = '0;
        @(negedge clk);
        start = 1'b1; ch_mask = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; ch_mask = 4'($urandom);
        chk({tag, " busy after start"}, 32'(busy), 32'(n != 0));
        chk({tag, " done cleared"}, 32'(done), 32'd0);
        for (int e = 1; e <= lat; e++) begin
            if (e == extra_e) begin start = 1'b1; ch_mask = m2; end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (!$onehot0(cal_en)) overlap = 1'b1;
            if (cal_en != '0 && cal_en != prev) seq.push_back(cal_en);
            prev = cal_en;
            if (e < lat && done !== 1'b0) early = 1'b1;
            if (busy !== (e < n * CH_LAT)) busy_bad = 1'b1;
        end
        chk({tag, " done at latency"}, 32'(done), 32'd1);
        chk({tag, " busy timeline"}, 32'(busy_bad), 32'd0);
        chk({tag, " no early done"}, 32'(early), 32'd0);
        chk({tag, " cal_en onehot"}, 32'(overlap), 32'd0);
        chk({tag, " cal_en idle"}, 32'(cal_en), 32'd0);
        for (int i = 0; i < N_CH; i++) if (m[i]) expseq.push_back(4'(1 << i));
        chk({tag, " visit count"}, 32'(seq.size()), 32'(expseq.size()));
        for (int i = 0; i < expseq.size(); i++) begin
            obs = (i < seq.size()) ? seq[i] : 4'h0;
            chk($sformatf("%s visit %0d", tag, i), 32'(obs), 32'(expseq[i]));
        end
        model_update(m);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rm;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = '0;
        for (int i = 0; i < N_CH; i++) tgt[i] = $urandom_range(1, 62);
        do_reset();

        // Reset state
        check_all("reset");
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset cal_en", 32'(cal_en), 32'd0);

        // Single channel, known target
        tgt[0] = 37;
        run_cal(4'b0001, -1, 4'b0000, "ch0_t37");

        // Saturating targets on two channels
        tgt[1] = 0; tgt[3] = MAXC;
        run_cal(4'b1010, -1, 4'b0000, "m1010_sat");

        // Empty mask: done one edge after acceptance, busy never asserts
        run_cal(4'b0000, -1, 4'b0000, "m0000");

        // start and abort together while idle: start ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1; ch_mask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort done kept", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("start+abort still idle", 32'(busy), 32'd0);

        // Abort during channel 2 settle
        do_reset();
        for (int i = 0; i < N_CH; i++) tgt[i] = $urandom_range(0, MAXC);
        @(negedge clk);
        start = 1'b1; ch_mask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * CH_LAT + 4) begin @(posedge clk); @(negedge clk); end
        chk("abort ch2 active", 32'(cal_en), 32'b0100);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cal_en", 32'(cal_en), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        model_update(4'b0011);
        check_all("abort");
        repeat (4) @(negedge clk);
        chk("abort done stays", 32'(done), 32'd0);
        chk("abort stays idle", 32'(busy), 32'd0);

        // Second start mid-run ignored, then a third start recalibrates
        for (int i = 0; i < N_CH; i++) tgt[i] = $urandom_range(0, MAXC);
        run_cal(4'b0101, 30, 4'b1010, "restart_ignored");
        for (int i = 0; i < N_CH; i++) tgt[i] = $urandom_range(0, MAXC);
        run_cal(4'b1010, -1, 4'b0000, "third_start");

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_CH; i++) tgt[i] = $urandom_range(0, MAXC);
            rm = 4'($urandom);
            run_cal(rm, -1, 4'b0000, $sformatf("rand%0d", r));
        end

        // Async reset while in the first decide cycle
        tgt[3] = 0;
        run_cal(4'b1000, -1, 4'b0000, "pre_rst");
        tgt[0] = $urandom_range(1, 62);
        @(negedge clk);
        start = 1'b1; ch_mask = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE_CYC + 1) begin @(posedge clk); @(negedge clk); end
        chk("pre-rst busy", 32'(busy), 32'd1);
        chk("pre-rst cal_en", 32'(cal_en), 32'b0001);
        rst = 1'b1;
        #1;
        for (int i = 0; i < N_CH; i++) exp_trim[i] = MID;
        exp_fail = '0;
        check_all("async_rst");
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst done", 32'(done), 32'd0);
        chk("async_rst cal_en", 32'(cal_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
